// File: rtl/seg7_frame_decoder.sv
// Decodes a stream of active-low 7-segment digits (H, E, L, O, blank) into 3-bit codes
// and packs NUM_DIGITS of them into a frame word. Optional hello_match output: SEG7_HELLO_MATCH_EN.
module seg7_frame_decoder #(
    parameter int NUM_DIGITS = 5,
    parameter int CODE_W     = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [6:0]                   seg_in,
    input  logic                         seg_valid,
    output logic                         seg_ready,
    input  logic                         frame_sync,
    output logic [NUM_DIGITS*CODE_W-1:0] frame_out,
    output logic                         frame_valid,
    input  logic                         frame_ready,
    output logic                         frame_err
`ifdef SEG7_HELLO_MATCH_EN
    ,
    output logic                         hello_match
`endif
);

    localparam int FRAME_W = NUM_DIGITS * CODE_W;
    localparam int CNT_W   = $clog2(NUM_DIGITS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

    // Handshakes: a digit moves on a clock edge where seg_valid && seg_ready;
    // a frame moves on a clock edge where frame_valid && frame_ready.
    typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     count;
    logic                 sticky;
    logic [FRAME_W-1:0]   assembly;
    logic [CODE_W-1:0]    dec_code;
    logic                 dec_err;
    logic                 accept;
    logic                 frame_done;
    logic [FRAME_W-1:0]   frame_next;

    always_comb begin
        dec_err  = 1'b0;
        dec_code = 3'b111;
        case (seg_in)
            7'b0001001: dec_code = 3'b000;
            7'b0000110: dec_code = 3'b001;
            7'b1000111: dec_code = 3'b010;
            7'b1000000: dec_code = 3'b011;
            7'b1111111: dec_code = 3'b100;
            default:    dec_err  = 1'b1;
        endcase
    end

    assign accept     = seg_valid && seg_ready;
    // A sync arriving with the last digit restarts the frame instead of completing it.
    assign frame_done = accept && !frame_sync && (count == LAST_CNT);
    assign frame_next = {assembly[FRAME_W-CODE_W-1:0], dec_code};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (frame_done) state_next = HOLD;
            HOLD:    if (frame_ready) state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    always_comb begin
        seg_ready   = rst_n && (state == COLLECT);
        frame_valid = rst_n && (state == HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count     <= '0;
            sticky    <= 1'b0;
            assembly  <= '0;
            frame_out <= '0;
            frame_err <= 1'b0;
        end else if (state == COLLECT) begin
            if (accept) begin
                assembly <= frame_next;
                if (frame_sync) begin
                    count  <= CNT_W'(1);
                    sticky <= dec_err;
                end else if (count == LAST_CNT) begin
                    frame_out <= frame_next;
                    frame_err <= sticky | dec_err;
                    count     <= '0;
                    sticky    <= 1'b0;
                end else begin
                    count  <= count + CNT_W'(1);
                    sticky <= sticky | dec_err;
                end
            end else if (frame_sync) begin
                count  <= '0;
                sticky <= 1'b0;
            end
        end
    end

`ifdef SEG7_HELLO_MATCH_EN
    localparam logic [14:0] HELLO_WORD = 15'b000_001_010_010_011;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hello_match <= 1'b0;
        end else if (state == COLLECT && frame_done) begin
            hello_match <= (NUM_DIGITS == 5) && !(sticky | dec_err) &&
                           (frame_next == FRAME_W'(HELLO_WORD));
        end
    end
`endif

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Scoreboard bench for seg7_frame_decoder: drivers push expected frames, a monitor pops
// and compares on every frame handshake. Builds with or without SEG7_HELLO_MATCH_EN.
module tb_seg7_frame_decoder;

    localparam int ND = 5;
    localparam int FW = ND * 3;
    localparam logic [6:0] S_H = 7'b0001001;
    localparam logic [6:0] S_E = 7'b0000110;
    localparam logic [6:0] S_L = 7'b1000111;
    localparam logic [6:0] S_O = 7'b1000000;
    localparam logic [6:0] S_B = 7'b1111111;
    localparam logic [6:0] S_X = 7'b0101010;
    localparam logic [FW-1:0] HELLO = 15'b000_001_010_010_011;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    seg_in = '0;
    logic          seg_valid = 1'b0;
    logic          seg_ready;
    logic          frame_sync = 1'b0;
    logic [FW-1:0] frame_out;
    logic          frame_valid;
    logic          frame_ready = 1'b1;
    logic          frame_err;
`ifdef SEG7_HELLO_MATCH_EN
    logic          hello_match;
`endif

    // Queue entry: {hello_expected, err_expected, frame_expected}
    logic [FW+1:0] exp_q[$];
    int n_vec  = 0;
    int n_fail = 0;

    seg7_frame_decoder #(.NUM_DIGITS(ND), .CODE_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .seg_valid(seg_valid),
        .seg_ready(seg_ready), .frame_sync(frame_sync), .frame_out(frame_out),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_err(frame_err)
`ifdef SEG7_HELLO_MATCH_EN
        , .hello_match(hello_match)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_frame(input logic [FW-1:0] f, input logic err);
        logic hello;
        hello = (f == HELLO) && !err;
        exp_q.push_back({hello, err, f});
    endtask

    // Monitor: every completed frame transfer is checked against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && frame_valid && frame_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 32'(frame_out), 32'hdead);
            end else begin
                logic [FW+1:0] e;
                e = exp_q.pop_front();
                check("frame_out", 32'(frame_out), 32'(e[FW-1:0]));
                check("frame_err", 32'(frame_err), 32'(e[FW]));
`ifdef SEG7_HELLO_MATCH_EN
                check("hello_match", 32'(hello_match), 32'(e[FW+1]));
`endif
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input logic [6:0] s, input logic sync);
        int n;
        n = 0;
        seg_in = s;
        seg_valid = 1'b1;
        frame_sync = sync;
        while (!seg_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) check("seg_ready_timeout", 32'(seg_ready), 32'd1);
        @(posedge clk);
        #1;
        seg_valid = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic send5(input logic [34:0] segs);
        for (int i = 4; i >= 0; i--) send(segs[i*7 +: 7], 1'b0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_seg_ready", 32'(seg_ready), 32'd0);
        check("rst_frame_valid", 32'(frame_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        // Reset state
        rst_n = 1'b0;
        cycles(2);
        @(negedge clk);
        check("reset_seg_ready", 32'(seg_ready), 32'd0);
        check("reset_frame_valid", 32'(frame_valid), 32'd0);
        check("reset_frame_out", 32'(frame_out), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_seg_ready", 32'(seg_ready), 32'd1);
        @(posedge clk);
        #1;

        // 1: HELLO back-to-back, valid one cycle after the fifth accept
        expect_frame(15'b000_001_010_010_011, 1'b0);
        send5({S_H, S_E, S_L, S_L, S_O});
        check("valid_latency", 32'(frame_valid), 32'd1);
        cycles(1);

        // 2: backpressure; a sync pulse in HOLD must be ignored
        frame_ready = 1'b0;
        expect_frame(15'b000_001_010_010_011, 1'b0);
        send5({S_H, S_E, S_L, S_L, S_O});
        expect_frame(15'b000_001_010_010_011, 1'b0);
        fork
            send(S_H, 1'b0);
            begin
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("hold_valid", 32'(frame_valid), 32'd1);
                    check("hold_seg_ready", 32'(seg_ready), 32'd0);
                    check("hold_frame_out", 32'(frame_out), 32'(HELLO));
                    if (i == 1) begin
                        @(posedge clk);
                        #1;
                        frame_sync = 1'b1;
                        @(posedge clk);
                        #1;
                        frame_sync = 1'b0;
                    end
                end
                @(posedge clk);
                #1;
                frame_ready = 1'b1;
                @(negedge clk);
                check("release_seg_ready_same", 32'(seg_ready), 32'd0);
                @(negedge clk);
                check("release_seg_ready_next", 32'(seg_ready), 32'd1);
            end
        join
        send(S_E, 1'b0);
        send(S_L, 1'b0);
        send(S_L, 1'b0);
        send(S_O, 1'b0);
        cycles(1);

        // 3: unrecognised third digit, then a clean frame clears the error
        expect_frame(15'b000_001_111_010_011, 1'b1);
        send5({S_H, S_E, S_X, S_L, S_O});
        cycles(1);
        expect_frame(15'b011_010_001_000_100, 1'b0);
        send5({S_O, S_L, S_E, S_H, S_B});
        cycles(1);

        // 4: partial frame (with an error) discarded by a lone sync
        send(S_H, 1'b0);
        send(S_X, 1'b0);
        send(S_L, 1'b0);
        frame_sync = 1'b1;
        cycles(1);
        frame_sync = 1'b0;
        expect_frame(15'b100_100_100_100_100, 1'b0);
        send5({S_B, S_B, S_B, S_B, S_B});
        cycles(1);

        // 5: sync on an accepted H starts a new frame
        send(S_E, 1'b0);
        send(S_E, 1'b0);
        expect_frame(15'b000_001_010_010_011, 1'b0);
        send(S_H, 1'b1);
        send(S_E, 1'b0);
        send(S_L, 1'b0);
        send(S_L, 1'b0);
        send(S_O, 1'b0);
        cycles(1);

        // 6: reset mid-frame, then reset during HOLD
        send(S_O, 1'b0);
        send(S_O, 1'b0);
        pulse_reset();
        @(negedge clk);
        check("rst_mid_valid", 32'(frame_valid), 32'd0);
        check("rst_mid_frame_out", 32'(frame_out), 32'd0);
        @(posedge clk);
        #1;
        frame_ready = 1'b0;
        send5({S_L, S_L, S_L, S_L, S_L});
        check("pre_rst_hold_valid", 32'(frame_valid), 32'd1);
        pulse_reset();
        @(negedge clk);
        check("rst_hold_valid", 32'(frame_valid), 32'd0);
        check("rst_hold_frame_out", 32'(frame_out), 32'd0);
        check("rst_hold_frame_err", 32'(frame_err), 32'd0);
        check("rst_hold_seg_ready", 32'(seg_ready), 32'd1);
        @(posedge clk);
        #1;
        frame_ready = 1'b1;
        cycles(3);
        check("no_stale_valid", 32'(frame_valid), 32'd0);
        expect_frame(15'b010_011_100_001_000, 1'b0);
        send5({S_L, S_O, S_B, S_E, S_H});
        cycles(1);

        // Drain scoreboard
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            cycles(1);
            n++;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
